// File: rtl/mem_if_pkg.sv
// Shared encodings for the CPU-side memory initiator: transfer sizes,
// error codes and the handshake sequencer states.
package mem_if_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_ILLEGAL = 2'b10;
  localparam logic [1:0] SZ_WORD    = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    RELEASE
  } state_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    return ((size == SZ_WORD) && (addrLo != 2'b00)) || ((size == SZ_HALF) && addrLo[0]);
  endfunction

endpackage

// File: rtl/mem_access_initiator_if.sv
// Request/response bundle between control unit, initiator and ram512x8.
// master = initiator view, slave = control unit plus RAM view.
interface mem_access_initiator_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              req;
  logic              reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [31:0]       reqWData;
  logic [1:0]        reqSize;
  logic              reqSigned;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        errCode;
  logic [31:0]       rdata;
  logic              memFuncActive;
  logic              readWrite;
  logic [ADDR_W-1:0] address;
  logic [31:0]       dataIn;
  logic [1:0]        dataSize;
  logic [31:0]       dataOut;
  logic              memFuncComplete;

  modport master (
    input  req, reqWrite, reqAddr, reqWData, reqSize, reqSigned,
    output busy, done, err, errCode, rdata,
    output memFuncActive, readWrite, address, dataIn, dataSize,
    input  dataOut, memFuncComplete
  );

  modport slave (
    output req, reqWrite, reqAddr, reqWData, reqSize, reqSigned,
    input  busy, done, err, errCode, rdata,
    input  memFuncActive, readWrite, address, dataIn, dataSize,
    output dataOut, memFuncComplete
  );
endinterface

// File: rtl/load_extender.sv
// Right-justified load data extension: halfword/byte are sign- or
// zero-extended to 32 bits, words pass through.
module load_extender
  import mem_if_pkg::*;
(
  input  logic [31:0] dataOut,
  input  logic [1:0]  size,
  input  logic        signExt,
  output logic [31:0] extData
);

  always_comb begin
    extData = dataOut;
    case (size)
      SZ_HALF: extData = {{16{signExt & dataOut[15]}}, dataOut[15:0]};
      SZ_BYTE: extData = {{24{signExt & dataOut[7]}}, dataOut[7:0]};
      default: extData = dataOut;
    endcase
  end

endmodule

// File: rtl/mem_access_initiator.sv
// Single-request load/store initiator for the ram512x8 level handshake.
// Every output is a register, so RAM-side controls never glitch.
module mem_access_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic                    Clk,
  input logic                    Reset_n,
  mem_access_initiator_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  state_t            stateQ, stateD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic              busyQ, busyD;
  logic              doneQ, doneD;
  logic              errQ, errD;
  logic [1:0]        errCodeQ, errCodeD;
  logic [31:0]       rdataQ, rdataD;
  logic              activeQ, activeD;
  logic              rwQ, rwD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [31:0]       dataInQ, dataInD;
  logic [1:0]        sizeQ, sizeD;
  logic              signedQ, signedD;
  logic [31:0]       extData;

  load_extender uExt (
    .dataOut (bus.dataOut),
    .size    (sizeQ),
    .signExt (signedQ),
    .extData (extData)
  );

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    errD     = errQ;
    errCodeD = errCodeQ;
    rdataD   = rdataQ;
    rwD      = rwQ;
    addrD    = addrQ;
    dataInD  = dataInQ;
    sizeD    = sizeQ;
    signedD  = signedQ;

    case (stateQ)
      IDLE: begin
        if (bus.req) begin
          signedD  = bus.reqSigned;
          errD     = 1'b0;
          errCodeD = ERR_NONE;
          if (bus.reqSize == SZ_ILLEGAL) begin
            stateD   = RELEASE;
            errD     = 1'b1;
            errCodeD = ERR_SIZE;
          end else if (isMisaligned(bus.reqSize, bus.reqAddr[1:0])) begin
            stateD   = RELEASE;
            errD     = 1'b1;
            errCodeD = ERR_MISALIGN;
          end else begin
            // RAM-side fields only move on a legal request, one cycle ahead of activation
            stateD  = SETUP;
            rwD     = bus.reqWrite;
            addrD   = bus.reqAddr;
            sizeD   = bus.reqSize;
            dataInD = bus.reqWrite ? bus.reqWData : '0;
          end
        end
      end
      SETUP: stateD = ACTIVE;
      ACTIVE: begin
        cntD = cntQ + CNT_W'(1);
        if (bus.memFuncComplete) begin
          stateD = RELEASE;
          if (!rwQ) rdataD = extData;
        end else if (cntD == CNT_LAST) begin
          stateD   = RELEASE;
          errD     = 1'b1;
          errCodeD = ERR_TIMEOUT;
        end
      end
      RELEASE: begin
        stateD = IDLE;
        cntD   = '0;
      end
      default: stateD = IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state
    busyD   = (stateD != IDLE);
    doneD   = (stateD == RELEASE);
    activeD = (stateD == ACTIVE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ   <= IDLE;
      cntQ     <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      errQ     <= 1'b0;
      errCodeQ <= ERR_NONE;
      rdataQ   <= '0;
      activeQ  <= 1'b0;
      rwQ      <= 1'b0;
      addrQ    <= '0;
      dataInQ  <= '0;
      sizeQ    <= '0;
      signedQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      errQ     <= errD;
      errCodeQ <= errCodeD;
      rdataQ   <= rdataD;
      activeQ  <= activeD;
      rwQ      <= rwD;
      addrQ    <= addrD;
      dataInQ  <= dataInD;
      sizeQ    <= sizeD;
      signedQ  <= signedD;
    end
  end

  assign bus.busy          = busyQ;
  assign bus.done          = doneQ;
  assign bus.err           = errQ;
  assign bus.errCode       = errCodeQ;
  assign bus.rdata         = rdataQ;
  assign bus.memFuncActive = activeQ;
  assign bus.readWrite     = rwQ;
  assign bus.address       = addrQ;
  assign bus.dataIn        = dataInQ;
  assign bus.dataSize      = sizeQ;

endmodule

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- CPU-side initiator for the ram512x8 handshake (memFuncActive/memFuncComplete, readWrite, address, dataIn, dataSize, dataOut).
- Accepts one load/store request from the datapath/control unit.
- Sequences the level-sensitive memory handshake, checks alignment and size, and sign/zero-extends load data.
- Reports completion or error with a single-cycle done pulse. Sits between the control unit and RAM.

Parameters:
ADDR_W, 9, memory byte-address width
TIMEOUT_CYCLES, 15, max cycles in ACTIVE waiting for memFuncComplete before error (counter width = clog2(TIMEOUT_CYCLES+1))

Ports:
Clk  input  1  system clock, all state on rising edge
Reset_n  input  1  asynchronous active-low reset
req  input  1  request strobe, sampled only in IDLE
reqWrite  input  1  1 = store, 0 = load
reqAddr  input  ADDR_W  byte address
reqWData  input  32  store data, right-justified for half/byte
reqSize  input  2  2'b11 word, 2'b01 halfword, 2'b00 byte, 2'b10 illegal
reqSigned  input  1  loads only: 1 = sign-extend, 0 = zero-extend
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse in RELEASE
err  output  1  valid with done; 1 = access failed
errCode  output  2  00 none, 01 misaligned, 10 illegal size, 11 timeout
rdata  output  32  extended load data, held until next done
memFuncActive  output  1  to RAM, request level
readWrite  output  1  to RAM, 1 = write
address  output  ADDR_W  to RAM
dataIn  output  32  to RAM, store data
dataSize  output  2  to RAM
dataOut  input  32  from RAM, read data
memFuncComplete  input  1  from RAM, completion level

Behaviour:
- Reset: async on Reset_n low. All outputs 0, state IDLE, timeout counter 0. memFuncActive drops immediately, including mid-access. After release, the first request is accepted normally.
- Registered outputs: all outputs. RAM-side signals never glitch.
- FSM states: IDLE, SETUP, ACTIVE, RELEASE.
- IDLE, req=1 at an edge:
  - Latch all req* fields.
  - Illegal size → RELEASE with err=1, errCode=10. No RAM access.
  - Word with addr[1:0]!=0, or halfword with addr[0]!=0 → RELEASE with errCode=01. No RAM access.
  - Otherwise → SETUP.
- req while busy: ignored, not queued.
- SETUP:
  - Drive address, readWrite, dataSize, and dataIn = reqWData (writes) or 0 (reads).
  - memFuncActive stays 0 so the RAM sees stable readWrite/address before activation.
  - → ACTIVE.
- ACTIVE:
  - memFuncActive = 1. readWrite, address, dataSize and dataIn are held constant; the RAM retriggers on any readWrite edge.
  - Counter increments each cycle.
  - memFuncComplete sampled 1 → capture, then RELEASE.
  - Counter reaches TIMEOUT_CYCLES without complete → RELEASE with errCode=11, rdata unchanged.
  - Complete and timeout in the same cycle: complete wins.
- Load capture:
  - Word: rdata = dataOut.
  - Halfword: rdata = {16{reqSigned & dataOut[15]}, dataOut[15:0]}.
  - Byte: rdata = {24{reqSigned & dataOut[7]}, dataOut[7:0]}.
  - Stores leave rdata unchanged.
- RELEASE:
  - memFuncActive = 0, done = 1 for exactly one cycle, err/errCode valid.
  - Counter cleared → IDLE.
  - err and errCode are cleared on the next accepted req.
- Latency: req edge → done high 3 cycles later (edge0 →SETUP, edge1 →ACTIVE, edge2 sees complete →RELEASE). Error-at-decode path: done 1 cycle after req.
- Spacing: memFuncActive is low for ≥2 cycles between accesses (RELEASE, IDLE sample, SETUP), so every access is a clean rising level.
- Address arithmetic is not performed here. The RAM handles address+1..+3 and wraps mod 512. A word at 508 is legal; any wrap beyond that is the RAM's behaviour.

Decomposition:
- Shared package mem_if_pkg:
  - Size encodings WORD=2'b11, HALF=2'b01, BYTE=2'b00.
  - errCode constants.
  - FSM state enum.
- Optional sub-module load_extender: combinational size/sign extension of dataOut. Everything else stays in this module.

Test Plan:
- RAM preloaded, word 0x00000821 at addr 0: load word, addr 0, size 11 → done 3 cycles after req, rdata=0x00000821, err=0, memFuncActive high exactly 1 cycle.
- Store word 0xDEADBEEF at addr 40, then load byte signed at addr 41 → rdata=0xFFFFFFAD. Load half unsigned at addr 42 → rdata=0x0000BEEF.
- Load word at addr 2 → done 1 cycle after req, err=1, errCode=01, memFuncActive never asserted. Same response with size 10 → errCode=10.
- RAM model with memFuncComplete stuck 0 → done after SETUP+15 ACTIVE cycles, errCode=11, memFuncActive returns to 0, next request succeeds.
- Reset_n pulled low during ACTIVE → memFuncActive, busy, done drop asynchronously. The first req after reset completes with correct data.
- req held high continuously through two accesses → second accepted only from IDLE, memFuncActive low ≥2 cycles between them, two distinct done pulses.
